// File: rtl/hazard_control.sv
// Hazard detection and forwarding control for a five-stage pipeline.
// A shadow copy of the EX, MEM and WB stages follows the real pipeline
// registers using the same enables and flushes. It drives the forwarding
// selects, and a RUN/STALL FSM drives the PC and IF/ID enables and the flushes.
module hazard_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_r2,
    input  logic        id_uses_rn,
    input  logic        id_uses_r2,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_setflag,
    input  logic        id_useflags,
    input  logic        id_cbz,
    input  logic        br_taken_mem,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cycles
);

    // Full decode tuple, kept for the instruction in EX.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       setflag;
        logic [4:0] rn;
        logic [4:0] r2;
        logic       uses_rn;
        logic       uses_r2;
    } ex_entry_t;

    // Past EX only the destination is consulted, so MEM and WB carry just that.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } dst_entry_t;

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    ex_entry_t  ex_q, ex_d;
    dst_entry_t mem_q, mem_d, wb_q, wb_d;
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic       load_use, flag_haz, cbz_ex, cbz_mem;
    logic [1:0] need, owed;
    logic       stall;

    // A stage entry writes register r only if valid, writing and not XZR.
    function automatic logic writes(input logic v, input logic rw,
                                    input logic [4:0] rd, input logic [4:0] r);
        return v && rw && (rd != 5'd31) && (rd == r);
    endfunction

    // Hazard evaluation for the instruction sitting in ID.
    always_comb begin
        load_use = id_valid && ex_q.memread &&
                   ((id_uses_rn && writes(ex_q.valid, ex_q.regwrite, ex_q.rd, id_rn)) ||
                    (id_uses_r2 && writes(ex_q.valid, ex_q.regwrite, ex_q.rd, id_r2)));
        flag_haz = id_valid && id_useflags && ex_q.valid && ex_q.setflag;
        cbz_ex   = id_valid && id_cbz && writes(ex_q.valid, ex_q.regwrite, ex_q.rd, id_r2);
        cbz_mem  = id_valid && id_cbz && writes(mem_q.valid, mem_q.regwrite, mem_q.rd, id_r2);
        if (cbz_ex)
            need = 2'd2;
        else if (load_use || flag_haz || cbz_mem)
            need = 2'd1;
        else
            need = 2'd0;
        // cnt_q holds the stall cycles still owed from earlier decisions; the larger wins.
        owed  = (state_q == STALL && cnt_q > need) ? cnt_q : need;
        stall = !reset && !br_taken_mem && (owed != 2'd0);
    end

    // FSM next state: a taken branch forces RUN; otherwise track owed stall cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (br_taken_mem) begin
            state_d = RUN;
            cnt_d   = 2'd0;
        end else if (owed != 2'd0) begin
            state_d = STALL;
            cnt_d   = owed - 2'd1;
        end else begin
            state_d = RUN;
            cnt_d   = 2'd0;
        end
    end

    // Enables and flushes, combinational so they act in the current cycle.
    always_comb begin
        pc_en       = !stall;
        ifid_en     = !stall;
        ifid_flush  = !reset && br_taken_mem;
        idex_flush  = !reset && (br_taken_mem || stall);
        exmem_flush = !reset && br_taken_mem;
    end

    // Shadow pipeline advance, mirroring the bubbles the flushes create.
    always_comb begin
        ex_d          = '0;
        ex_d.valid    = id_valid;
        ex_d.rd       = id_rd;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        ex_d.setflag  = id_setflag;
        ex_d.rn       = id_rn;
        ex_d.r2       = id_r2;
        ex_d.uses_rn  = id_uses_rn;
        ex_d.uses_r2  = id_uses_r2;
        if (idex_flush || !id_valid)
            ex_d = '0;
        mem_d = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
        if (exmem_flush)
            mem_d = '0;
        wb_d = mem_q;
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // State registers; reset clears everything at once, aborting any stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Forwarding selects for the EX operands; MEM takes priority over WB.
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (ex_q.valid && ex_q.uses_rn) begin
            if (writes(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rn))
                fwd_a = 2'd2;
            else if (writes(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rn))
                fwd_a = 2'd1;
        end
        if (ex_q.valid && ex_q.uses_r2) begin
            if (writes(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.r2))
                fwd_b = 2'd2;
            else if (writes(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.r2))
                fwd_b = 2'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed testbench for hazard_control: instruction sequences are driven into
// ID one per cycle and the control outputs are compared against hand-derived values.
module tb_hazard_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rd, id_rn, id_r2;
    logic        id_uses_rn, id_uses_r2, id_regwrite, id_memread;
    logic        id_setflag, id_useflags, id_cbz, br_taken_mem;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_control dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rd(id_rd), .id_rn(id_rn), .id_r2(id_r2),
        .id_uses_rn(id_uses_rn), .id_uses_r2(id_uses_r2),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_setflag(id_setflag), .id_useflags(id_useflags), .id_cbz(id_cbz),
        .br_taken_mem(br_taken_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rd, input logic [4:0] rn,
                            input logic [4:0] r2, input logic urn, input logic ur2,
                            input logic rw, input logic mr, input logic sf,
                            input logic uf, input logic cbz);
        id_valid = v;   id_rd = rd;      id_rn = rn;      id_r2 = r2;
        id_uses_rn = urn; id_uses_r2 = ur2; id_regwrite = rw; id_memread = mr;
        id_setflag = sf; id_useflags = uf; id_cbz = cbz;
        #1;
    endtask

    task automatic op_nop();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic op_alu(input logic [4:0] rd, input logic [4:0] rn,
                          input logic [4:0] r2, input logic sf);
        drive_id(1'b1, rd, rn, r2, 1'b1, 1'b1, 1'b1, 1'b0, sf, 1'b0, 1'b0);
    endtask
    task automatic op_ldur(input logic [4:0] rd, input logic [4:0] rn);
        drive_id(1'b1, rd, rn, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic op_cbz(input logic [4:0] rt);
        drive_id(1'b1, 5'd0, 5'd0, rt, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic op_bcond();
        drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Advance one clock; inputs are then changed 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        br_taken_mem = 1'b0;
        op_nop();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values, including a branch request that reset must mask.
        reset = 1'b1;
        br_taken_mem = 1'b1;
        op_nop();
        #2;
        check("rst_pc_en", {31'd0, pc_en}, 32'd1);
        check("rst_ifid_en", {31'd0, ifid_en}, 32'd1);
        check("rst_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd0);
        check("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        do_reset();

        // ADDS X1 ; ADD X2,X1,X3 : no stall, EX/MEM forwarding on operand A.
        op_alu(5'd1, 5'd2, 5'd3, 1'b1);
        check("adds_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        op_alu(5'd2, 5'd1, 5'd3, 1'b0);
        check("raw_no_stall", {31'd0, pc_en}, 32'd1);
        tick();
        op_nop();
        check("raw_fwd_a_mem", {30'd0, fwd_a}, 32'd2);
        check("raw_fwd_b_none", {30'd0, fwd_b}, 32'd0);
        tick();
        check("bubble_in_ex_fwd_a", {30'd0, fwd_a}, 32'd0);

        // Two writers of X4 in MEM and WB: MEM wins.
        op_alu(5'd4, 5'd1, 5'd1, 1'b0); tick();
        op_alu(5'd4, 5'd1, 5'd1, 1'b0); tick();
        op_alu(5'd6, 5'd4, 5'd4, 1'b0); tick();
        op_nop();
        check("prio_fwd_a", {30'd0, fwd_a}, 32'd2);
        check("prio_fwd_b", {30'd0, fwd_b}, 32'd2);
        // Producer two ahead: WB forwarding on A only.
        tick();
        op_alu(5'd7, 5'd1, 5'd1, 1'b0); tick();
        op_nop(); tick();
        op_alu(5'd8, 5'd7, 5'd9, 1'b0); tick();
        op_nop();
        check("wb_fwd_a", {30'd0, fwd_a}, 32'd1);
        check("wb_fwd_b", {30'd0, fwd_b}, 32'd0);
        // XZR never forwards.
        tick();
        op_alu(5'd31, 5'd1, 5'd1, 1'b0); tick();
        op_alu(5'd2, 5'd31, 5'd31, 1'b0); tick();
        op_nop();
        check("xzr_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        check("no_stall_total", stall_cycles, 32'd0);

        // LDUR X1 ; ADD X2,X1,X1 : one stall, then WB forwarding on both.
        do_reset();
        op_ldur(5'd1, 5'd2); tick();
        op_alu(5'd2, 5'd1, 5'd1, 1'b0);
        check("lu_pc_en", {31'd0, pc_en}, 32'd0);
        check("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
        check("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
        tick();
        op_alu(5'd2, 5'd1, 5'd1, 1'b0);
        check("lu_release_pc_en", {31'd0, pc_en}, 32'd1);
        check("lu_release_flush", {31'd0, idex_flush}, 32'd0);
        tick();
        op_nop();
        check("lu_fwd_a", {30'd0, fwd_a}, 32'd1);
        check("lu_fwd_b", {30'd0, fwd_b}, 32'd1);
        check("lu_stall_cycles", stall_cycles, 32'd1);

        // ADD X5 ; CBZ X5 : two stalls.
        do_reset();
        op_alu(5'd5, 5'd1, 5'd1, 1'b0); tick();
        op_cbz(5'd5);
        check("cbz_stall1", {31'd0, pc_en}, 32'd0);
        tick();
        op_cbz(5'd5);
        check("cbz_stall2", {31'd0, pc_en}, 32'd0);
        tick();
        op_cbz(5'd5);
        check("cbz_go", {31'd0, pc_en}, 32'd1);
        check("cbz_stall_cycles", stall_cycles, 32'd2);

        // Producers writing X31 never stall (CBZ and load-use).
        do_reset();
        op_alu(5'd31, 5'd1, 5'd1, 1'b0); tick();
        op_cbz(5'd31);
        check("cbz_xzr", {31'd0, pc_en}, 32'd1);
        tick();
        op_ldur(5'd31, 5'd2); tick();
        op_alu(5'd3, 5'd31, 5'd31, 1'b0);
        check("lu_xzr", {31'd0, pc_en}, 32'd1);
        tick();
        check("xzr_stall_cycles", stall_cycles, 32'd0);

        // SUBS ; B.LT : one stall on the flags.
        do_reset();
        op_alu(5'd3, 5'd1, 5'd2, 1'b1); tick();
        op_bcond();
        check("flag_stall", {31'd0, pc_en}, 32'd0);
        tick();
        op_bcond();
        check("flag_go", {31'd0, pc_en}, 32'd1);
        check("flag_stall_cycles", stall_cycles, 32'd1);

        // Taken branch in the second CBZ stall cycle overrides the stall.
        do_reset();
        op_alu(5'd5, 5'd1, 5'd1, 1'b0); tick();
        op_cbz(5'd5);
        check("br_pre_stall", {31'd0, pc_en}, 32'd0);
        tick();
        op_cbz(5'd5);
        br_taken_mem = 1'b1;
        #1;
        check("br_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd7);
        check("br_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        br_taken_mem = 1'b0;
        op_cbz(5'd5);
        check("br_then_run", {31'd0, pc_en}, 32'd1);
        check("br_then_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd0);

        // Reset in the middle of a CBZ stall aborts it immediately.
        do_reset();
        op_alu(5'd5, 5'd1, 5'd1, 1'b0); tick();
        op_cbz(5'd5); tick();
        op_cbz(5'd5);
        check("mid_stall_pc_en", {31'd0, pc_en}, 32'd0);
        check("mid_stall_count", stall_cycles, 32'd1);
        reset = 1'b1;
        br_taken_mem = 1'b1;
        #1;
        check("async_rst_enables", {30'd0, pc_en, ifid_en}, 32'd3);
        check("async_rst_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd0);
        check("async_rst_count", stall_cycles, 32'd0);
        br_taken_mem = 1'b0;
        tick();
        reset = 1'b0;
        op_cbz(5'd5);
        check("after_rst_run", {31'd0, pc_en}, 32'd1);

        // Counter saturation from just below the top.
        do_reset();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        op_ldur(5'd1, 5'd2); tick();
        op_alu(5'd2, 5'd1, 5'd1, 1'b0); tick();
        check("sat_reach_max", stall_cycles, 32'hFFFF_FFFF);
        op_alu(5'd2, 5'd1, 5'd1, 1'b0); tick();
        op_alu(5'd3, 5'd1, 5'd2, 1'b1); tick();
        op_bcond();
        check("sat_extra_stall", {31'd0, pc_en}, 32'd0);
        tick();
        check("sat_hold", stall_cycles, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 id_valid, id_rd[5], id_rn[5], id_r2[5], id_uses_rn, id_uses_r2  in  decode-stage instruction and its sources; id_r2 is the Reg2Loc-selected read register.
REQ-004 id_regwrite, id_memread, id_setflag, id_useflags, id_cbz  in  1 each  decode-stage control: register write, load, flag write, flag read (B.cond), CBZ register test in ID.
REQ-005 br_taken_mem  in  1  branch in MEM stage is taken; PC loads the target at the next edge.
REQ-006 pc_en, ifid_en  out  1 each  PC and IF/ID write enables.
REQ-007 ifid_flush, idex_flush, exmem_flush  out  1 each  zero the control fields of the named pipeline register at the next edge.
REQ-008 fwd_a[2], fwd_b[2]  out  forwarding-mux selects for the EX-stage ALU operands: 0 = ID/EX read data, 1 = WB result, 2 = EX/MEM ALU result; 3 is never driven.
REQ-009 stall_cycles[32]  out  saturating count of stall cycles.

Function
REQ-010 Shall keep a shadow pipeline of {valid, rd, regwrite, memread, setflag, rn, r2, uses_rn, uses_r2} for the EX, MEM and WB stages, advanced by the same enables and flushes it drives.
REQ-011 Register 31 (XZR) shall never match for hazard detection or forwarding.
REQ-012 fwd_a = 2 when EX.uses_rn and MEM.regwrite and MEM.rd == EX.rn; else 1 when WB.regwrite and WB.rd == EX.rn; else 0. fwd_b uses r2/uses_r2 the same way; MEM has priority over WB.
REQ-013 Load-use: EX.memread and EX.regwrite and EX.rd matches a used ID source -> one stall cycle, after which REQ-012 selects 1.
REQ-014 Flag hazard: id_useflags and EX.setflag -> one stall cycle.
REQ-015 CBZ hazard: id_cbz and id_r2 matches a writing EX.rd -> two stall cycles; matches a writing MEM.rd -> one stall cycle. WB-stage writes are visible in ID the same cycle, so no stall.
REQ-016 FSM states RUN and STALL with a 2-bit stall counter.
  - RUN -> STALL when any hazard in REQ-013..015 holds; the counter loads the maximum required count minus 1.
  - STALL decrements the counter each cycle and returns to RUN when it reaches 0.
  - Hazards are re-evaluated each cycle and the larger remaining count wins.
REQ-017 During a stall: pc_en = ifid_en = 0, idex_flush = 1 (bubble), and the shadow EX stage receives an invalid entry.
REQ-018 br_taken_mem = 1 -> ifid_flush = idex_flush = exmem_flush = 1 and pc_en = 1 in that cycle. The FSM goes to RUN and the counter clears at the edge.
REQ-019 br_taken_mem overrides any stall in the same cycle.
REQ-020 stall_cycles increments once per STALL cycle, saturates at 0xFFFFFFFF and does not wrap.
REQ-021 Flush and enable outputs shall be combinational from state and inputs, so they are valid in the same cycle. The fwd selects are combinational from shadow state.
REQ-022 Invalid shadow entries shall never cause a match.

Reset
REQ-023 While reset is high: state = RUN, counter = 0, all shadow entries invalid, stall_cycles = 0, pc_en = ifid_en = 1, all flushes = 0, fwd_a = fwd_b = 0.
REQ-024 Reset asserted mid-stall shall abort the stall immediately; the first cycle after release behaves as RUN.

Verification
REQ-025 ADDS X1 then ADD X2,X1,X3 back-to-back -> no stall; fwd_a = 2 when ADD is in EX.
REQ-026 LDUR X1 then ADD X2,X1,X1 -> exactly one cycle with pc_en = 0 and idex_flush = 1; then fwd_a = fwd_b = 1 and stall_cycles = 1.
REQ-027 ADD X5 then CBZ X5 -> two stall cycles with state STALL, then RUN; stall_cycles = 2. A producer writing X31 -> zero stalls.
REQ-028 SUBS then B.LT -> one stall cycle. br_taken_mem asserted during a stall -> all three flushes = 1 and pc_en = 1 that cycle; RUN on the next cycle.
REQ-029 Reset pulsed mid-stall -> outputs return to the REQ-023 values asynchronously; force stall_cycles near 0xFFFFFFFF and stall further -> it holds at 0xFFFFFFFF.
